// File: rtl/puf_seq_pkg.sv
// Shared types and constants for the PUF challenge sequencer.
// Holds the FSM state encoding, record layout and the response majority helper.
package puf_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    PUSH    = 3'd4
  } state_t;

  localparam int REC_W    = 16;
  localparam int FIELD_W  = 8;
  localparam int CHAL_LSB = 8;
  localparam int RESP_LSB = 0;
  localparam logic [31:0] ENABLE_ALL = 32'hFFFF_FFFF;

  // Bitwise 2-of-3 vote across three evaluations of the same challenge.
  function automatic logic [FIELD_W-1:0] maj3(input logic [FIELD_W-1:0] a,
                                               input logic [FIELD_W-1:0] b,
                                               input logic [FIELD_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/puf_challenge_sequencer_fifo.sv
// Synchronous record FIFO (DEPTH x WIDTH) with asynchronous active-high reset.
// Full is evaluated before any same-cycle read, so a write into a full FIFO waits a cycle.
module puf_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_wr & ~o_full;
  assign w_rd    = i_rd & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; memory is cleared so the head reads zero after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Sequencer that arms the PUF per challenge, captures responses and streams {challenge,response}.
// Optional macro PUF_RESP_VOTE_EN: three evaluations per challenge with bitwise majority.
module puf_challenge_sequencer
  import puf_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TO_W           = 26,
  parameter int ARM_CYCLES     = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  base_challenge,
  input  logic [7:0]  num_challenges,
  output logic        busy,
  output logic        seq_done,
  output logic        timeout_err,
  output logic [31:0] puf_enable,
  output logic [7:0]  puf_challenge,
  output logic        puf_reset,
  input  logic        puf_done,
  input  logic [7:0]  puf_response,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  state_t            r_state, w_state_n;
  logic [7:0]        r_chal;
  logic [8:0]        r_remaining;
  logic [7:0]        r_arm_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_done_d;
  logic [7:0]        r_resp;
  logic              r_busy, r_seq_done, r_timeout_err, r_puf_reset;
  logic [31:0]       r_enable;
  logic              w_done_rise, w_to_hit, w_arm_last, w_last, w_push, w_timeout;
  logic              w_fifo_full, w_fifo_empty, w_eval_last;
  logic [7:0]        w_resp_final;

  assign w_done_rise = puf_done & ~r_done_d;
  assign w_to_hit    = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_arm_last  = (r_arm_cnt == 8'(ARM_CYCLES - 1));
  assign w_last      = (r_remaining == 9'd1);
  assign w_push      = (r_state == PUSH) & ~w_fifo_full;

`ifdef PUF_RESP_VOTE_EN
  logic [1:0] r_pass;
  logic [7:0] r_vote0, r_vote1;

  assign w_eval_last  = (r_pass == 2'd2);
  assign w_resp_final = maj3(r_vote0, r_vote1, puf_response);

  // Pass counter and the first two votes of the current challenge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pass  <= 2'd0;
      r_vote0 <= 8'd0;
      r_vote1 <= 8'd0;
    end else if (r_state == IDLE) begin
      r_pass <= 2'd0;
    end else if (r_state == WAIT && w_done_rise) begin
      if (r_pass == 2'd0) r_vote0 <= puf_response;
      if (r_pass == 2'd1) r_vote1 <= puf_response;
      r_pass <= w_eval_last ? 2'd0 : r_pass + 2'd1;
    end
  end
`else
  assign w_eval_last  = 1'b1;
  assign w_resp_final = puf_response;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  // Next-state logic; a done edge wins over a timeout in the same cycle.
  always_comb begin
    w_state_n = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:    w_state_n = start ? ARM : IDLE;
      ARM:     w_state_n = w_arm_last ? WAIT : ARM;
      WAIT: begin
        if (w_done_rise) begin
          w_state_n = w_eval_last ? CAPTURE : ARM;
        end else if (w_to_hit) begin
          w_state_n = IDLE;
          w_timeout = 1'b1;
        end else begin
          w_state_n = WAIT;
        end
      end
      CAPTURE: w_state_n = PUSH;
      PUSH: begin
        if (w_push) w_state_n = w_last ? IDLE : ARM;
        else        w_state_n = PUSH;
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Run bookkeeping, counters and registered outputs derived from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_chal        <= 8'd0;
      r_remaining   <= 9'd0;
      r_arm_cnt     <= 8'd0;
      r_to_cnt      <= '0;
      r_done_d      <= 1'b0;
      r_resp        <= 8'd0;
      r_busy        <= 1'b0;
      r_seq_done    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_enable      <= 32'd0;
      r_puf_reset   <= 1'b1;
    end else begin
      r_done_d  <= puf_done;
      r_arm_cnt <= (r_state == ARM)  ? r_arm_cnt + 8'd1 : 8'd0;
      r_to_cnt  <= (r_state == WAIT) ? r_to_cnt + TO_W'(1) : '0;
      if (r_state == IDLE && start) begin
        r_chal        <= base_challenge;
        r_remaining   <= (num_challenges == 8'd0) ? 9'd256 : {1'b0, num_challenges};
        r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
      if (r_state == WAIT && w_done_rise && w_eval_last) r_resp <= w_resp_final;
      if (w_push) begin
        r_remaining <= r_remaining - 9'd1;
        if (!w_last) r_chal <= r_chal + 8'd1;
      end
      r_seq_done  <= w_push & w_last;
      r_busy      <= (w_state_n != IDLE);
      r_enable    <= (w_state_n == ARM || w_state_n == WAIT) ? ENABLE_ALL : 32'd0;
      r_puf_reset <= (w_state_n != WAIT);
    end
  end

  puf_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_wr    (w_push),
    .i_data  ({r_chal, r_resp}),
    .i_rd    (out_ready),
    .o_data  (out_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign busy          = r_busy;
  assign seq_done      = r_seq_done;
  assign timeout_err   = r_timeout_err;
  assign puf_enable    = r_enable;
  assign puf_challenge = r_chal;
  assign puf_reset     = r_puf_reset;
  assign out_valid     = ~w_fifo_empty;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench for puf_challenge_sequencer: PUF model, record scoreboard,
// table-driven runs and hand-written latency, backpressure, timeout and reset sequences.
module tb_puf_challenge_sequencer;

  localparam int TO  = 1000;
  localparam int ARM = 2;
  localparam int DLY = 100;
`ifdef PUF_RESP_VOTE_EN
  localparam int PASSES = 3;
`else
  localparam int PASSES = 1;
`endif

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic [7:0]  base_challenge = 8'd0, num_challenges = 8'd0;
  logic        busy, seq_done, timeout_err, puf_reset, out_valid;
  logic [31:0] puf_enable;
  logic [7:0]  puf_challenge;
  logic        puf_done = 1'b0;
  logic [7:0]  puf_response = 8'd0;
  logic [15:0] out_data;

  puf_challenge_sequencer #(
    .TIMEOUT_CYCLES (TO), .TO_W (11), .ARM_CYCLES (ARM), .FIFO_DEPTH (4)
  ) dut (
    .clock (clock), .reset (reset), .start (start),
    .base_challenge (base_challenge), .num_challenges (num_challenges),
    .busy (busy), .seq_done (seq_done), .timeout_err (timeout_err),
    .puf_enable (puf_enable), .puf_challenge (puf_challenge), .puf_reset (puf_reset),
    .puf_done (puf_done), .puf_response (puf_response),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  base;
    logic [7:0]  num;
    logic [15:0] first;
    logic [15:0] last;
    int          count;
  } vec_t;

  vec_t        vecs[4];
  int          checks = 0, failures = 0;
  logic [15:0] sb_q[$];
  int          rec_cnt = 0, seq_cnt = 0, pass_idx = 0;
  logic [15:0] first_rec = 16'd0, last_rec = 16'd0;
  bit          puf_never = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name, input int budget);
    checks++;
    failures++;
    $display("FAIL %s: no event within %0d cycles", name, budget);
  endtask

  task automatic do_start(input logic [7:0] b, input logic [7:0] n);
    base_challenge = b;
    num_challenges = n;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic push_run(input logic [7:0] b, input logic [7:0] n);
    int total;
    logic [7:0] c;
    total = (n == 8'd0) ? 256 : int'(n);
    for (int i = 0; i < total; i++) begin
      c = b + 8'(i);
      sb_q.push_back({c, ~c});
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    if (busy) bound_fail("wait_idle", budget);
  endtask

  task automatic clear_counts();
    rec_cnt = 0;
    seq_cnt = 0;
  endtask

  // PUF model: response ~challenge after DLY cycles in evaluation; vote passes flip one bit.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        puf_done = 1'b0; cnt = 0; pass_idx = 0;
      end else if (puf_reset) begin
        puf_done = 1'b0; cnt = 0;
      end else if (!puf_never && !puf_done) begin
        if (cnt == DLY - 1) begin
          puf_done     = 1'b1;
          puf_response = ~puf_challenge ^ ((pass_idx == 1) ? 8'h01 : (pass_idx == 2) ? 8'h80 : 8'h00);
          pass_idx     = (pass_idx + 1) % PASSES;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every handshake and counts seq_done pulses.
  initial begin
    logic [15:0] exp;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL record: got %0h expected none", out_data);
          end else begin
            exp = sb_q.pop_front();
            chk("record", out_data, exp);
            if (rec_cnt == 0) first_rec = out_data;
            last_rec = out_data;
            rec_cnt++;
          end
        end
        if (seq_done) seq_cnt++;
      end
    end
  end

  initial begin
    int n;
    vecs[0] = '{8'h10, 8'd3, 16'h10EF, 16'h12ED, 3};
    vecs[1] = '{8'hFE, 8'd3, 16'hFE01, 16'h00FF, 3};
    vecs[2] = '{8'h5A, 8'd1, 16'h5AA5, 16'h5AA5, 1};
    vecs[3] = '{8'h37, 8'd0, 16'h37C8, 16'h36C9, 256};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_seq_done", seq_done, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_puf_enable", puf_enable, 32'd0);
    chk("rst_puf_challenge", puf_challenge, 8'd0);
    chk("rst_puf_reset", puf_reset, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;

    // Latency: start to puf_reset falling, and done edge to record visible.
    clear_counts();
    push_run(8'h40, 8'd1);
    base_challenge = 8'h40; num_challenges = 8'd1; start = 1'b1;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
      if (n == 1) start = 1'b0;
    end while (puf_reset && n < 20);
    chk("start_to_reset_fall", n, ARM + 1);
    chk("arm_enable", puf_enable, 32'hFFFF_FFFF);
    for (int p = 0; p < PASSES; p++) begin
      n = 0;
      while (!puf_done && n < 400) begin @(posedge clock); #1; n++; end
      if (!puf_done) bound_fail("wait_done", 400);
      if (p < PASSES - 1) begin
        n = 0;
        while (puf_done && n < 20) begin @(posedge clock); #1; n++; end
      end
    end
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!out_valid && n < 20);
    chk("done_to_valid", n, 2);
    wait_idle(100);
    repeat (6) @(posedge clock);
    #1;
    chk("lat_rec_cnt", rec_cnt, 1);
    chk("lat_seq_cnt", seq_cnt, 1);

    // Table-driven runs.
    for (int k = 0; k < 4; k++) begin
      clear_counts();
      push_run(vecs[k].base, vecs[k].num);
      do_start(vecs[k].base, vecs[k].num);
      chk("busy_after_start", busy, 1'b1);
      wait_idle(40000 * PASSES);
      repeat (6) @(posedge clock);
      #1;
      chk("tbl_rec_cnt", rec_cnt, vecs[k].count);
      chk("tbl_first", first_rec, vecs[k].first);
      chk("tbl_last", last_rec, vecs[k].last);
      chk("tbl_seq_done", seq_cnt, 1);
      chk("tbl_timeout_err", timeout_err, 1'b0);
      chk("tbl_sb_empty", sb_q.size(), 0);
    end

    // Backpressure: FIFO fills, FSM stalls in PUSH; a start while busy is ignored.
    out_ready = 1'b0;
    clear_counts();
    push_run(8'h20, 8'd6);
    do_start(8'h20, 8'd6);
    repeat (700 * PASSES) @(posedge clock);
    #1;
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_busy", busy, 1'b1);
    chk("bp_puf_reset", puf_reset, 1'b1);
    chk("bp_puf_enable", puf_enable, 32'd0);
    chk("bp_head", out_data, 16'h20DF);
    do_start(8'hC0, 8'd1);
    repeat (3) @(posedge clock);
    #1;
    chk("bp_ignored_start", puf_challenge, 8'h24);
    chk("bp_head_stable", out_data, 16'h20DF);
    out_ready = 1'b1;
    wait_idle(2000 * PASSES);
    repeat (6) @(posedge clock);
    #1;
    chk("bp_rec_cnt", rec_cnt, 6);
    chk("bp_seq_done", seq_cnt, 1);
    chk("bp_sb_empty", sb_q.size(), 0);

    // Timeout: PUF never answers.
    puf_never = 1'b1;
    clear_counts();
    do_start(8'h55, 8'd2);
    n = 0;
    while (puf_reset && n < 20) begin @(posedge clock); #1; n++; end
    n = 0;
    while (!timeout_err && n < 3000) begin @(posedge clock); #1; n++; end
    chk("timeout_cycles", n, TO);
    chk("to_busy", busy, 1'b0);
    chk("to_puf_reset", puf_reset, 1'b1);
    chk("to_puf_enable", puf_enable, 32'd0);
    repeat (5) @(posedge clock);
    #1;
    chk("to_seq_done", seq_cnt, 0);
    chk("to_rec_cnt", rec_cnt, 0);
    puf_never = 1'b0;
    push_run(8'h60, 8'd1);
    do_start(8'h60, 8'd1);
    chk("to_cleared_by_start", timeout_err, 1'b0);
    wait_idle(500 * PASSES);
    repeat (6) @(posedge clock);
    #1;
    chk("to_next_rec_cnt", rec_cnt, 1);
    chk("to_next_seq_done", seq_cnt, 1);

    // Reset mid-WAIT with a record held in the FIFO.
    out_ready = 1'b0;
    clear_counts();
    do_start(8'h70, 8'd4);
    n = 0;
    while (!out_valid && n < 500 * PASSES) begin @(posedge clock); #1; n++; end
    if (!out_valid) bound_fail("mid_wait_record", 500 * PASSES);
    n = 0;
    while (puf_reset && n < 20) begin @(posedge clock); #1; n++; end
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_puf_reset", puf_reset, 1'b1);
    chk("mr_puf_enable", puf_enable, 32'd0);
    chk("mr_puf_challenge", puf_challenge, 8'd0);
    chk("mr_out_valid", out_valid, 1'b0);
    chk("mr_out_data", out_data, 16'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk("mr_fifo_empty", out_valid, 1'b0);
    chk("mr_no_records", rec_cnt, 0);
    chk("mr_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
